// File: rtl/seq_pkg.sv
// Shared types and helpers for the serial pattern detector family.
// Holds the FSM state encoding, the operating-mode constants and the
// active-length clamp used when a new pattern is loaded.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSCA  = 2'd1,
    ACHADO = 2'd2
  } estado_t;

  localparam logic MODO_UNICO    = 1'b0;
  localparam logic MODO_CONTINUO = 1'b1;

  // A length of zero, or one longer than the window, means "use the whole window".
  function automatic int eff_len(input int comprimento, input int w);
    if (comprimento == 0 || comprimento > w) begin
      return w;
    end
    return comprimento;
  endfunction

endpackage

// File: rtl/janela_deslizante.sv
// Sliding history window for the serial pattern detector.
// Shifts accepted bits into a W-bit history, tracks how many bits have been
// collected (saturating at W) and compares the would-be next window against
// the loaded pattern under the per-bit mask, limited to the active length.
// match_next reflects the window that results from the bit being accepted
// this cycle, so the top can register the flag on the same edge.
module janela_deslizante #(
  parameter int W  = 8,
  parameter int LW = $clog2(W + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          limpar,
  input  logic          deslocar,
  input  logic          bit_in,
  input  logic [W-1:0]  padrao,
  input  logic [W-1:0]  mascara,
  input  logic [LW-1:0] comprimento,
  output logic          match_next
);

  logic [W-1:0]  hist;
  logic [W-1:0]  hist_next;
  logic [W-1:0]  janela;
  logic [LW-1:0] fill;
  logic [LW-1:0] fill_next;

  // Next history and fill count, plus the masked compare restricted to the active length.
  always_comb begin
    hist_next = hist;
    fill_next = fill;
    janela    = '0;
    if (deslocar) begin
      hist_next = {hist[W-2:0], bit_in};
      if (fill != LW'(W)) begin
        fill_next = fill + LW'(1);
      end
    end
    for (int i = 0; i < W; i++) begin
      janela[i] = (i < int'(comprimento));
    end
    match_next = deslocar && (fill_next >= comprimento) &&
                 (((hist_next ^ padrao) & mascara & janela) == '0);
  end

  // History and fill registers; a clear request wins over shifting in a bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist <= '0;
      fill <= '0;
    end else if (limpar) begin
      hist <= '0;
      fill <= '0;
    end else begin
      hist <= hist_next;
      fill <= fill_next;
    end
  end

endmodule

// File: rtl/detector_sequencia_param.sv
// Parametrised serial pattern detector (successor of the 8-bit Sequencia block).
// Holds the configuration registers, the IDLE/BUSCA/ACHADO control FSM, the
// match flag and the optional saturating match counter; the sliding window
// and compare live in janela_deslizante.
// Optional feature: define SEQ_MATCH_COUNT_EN to build the match counter;
// without it contagem is tied to zero and no counter flops exist.
module detector_sequencia_param
  import seq_pkg::*;
#(
  parameter int W  = 8,
  parameter int LW = $clog2(W + 1),
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          setar_palavra,
  input  logic [W-1:0]  palavra,
  input  logic [W-1:0]  mascara,
  input  logic [LW-1:0] comprimento,
  input  logic          modo,
  input  logic          start,
  input  logic          bit_valid,
  input  logic          bit_in,
  output logic          encontrado,
  output logic          ocupado,
  output logic [CW-1:0] contagem
);

  estado_t       estado;
  estado_t       prox_estado;
  logic [W-1:0]  padrao;
  logic [W-1:0]  mascara_ativa;
  logic [LW-1:0] comp_ativo;
  logic          modo_ativo;
  logic          aceita;
  logic          limpar;
  logic          match_next;
  logic          achou;

  // A bit counts only in BUSCA, when valid, and when no higher-priority command is present.
  assign aceita = (estado == BUSCA) && bit_valid && !setar_palavra && !start;
  assign limpar = setar_palavra || start;
  assign achou  = aceita && match_next;

  janela_deslizante #(
    .W  (W),
    .LW (LW)
  ) u_janela (
    .clk         (clk),
    .rst_n       (rst_n),
    .limpar      (limpar),
    .deslocar    (aceita),
    .bit_in      (bit_in),
    .padrao      (padrao),
    .mascara     (mascara_ativa),
    .comprimento (comp_ativo),
    .match_next  (match_next)
  );

  // Configuration is captured only on setar_palavra, with the length clamped to the window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      padrao        <= '0;
      mascara_ativa <= '0;
      comp_ativo    <= LW'(W);
      modo_ativo    <= MODO_UNICO;
    end else if (setar_palavra) begin
      padrao        <= palavra;
      mascara_ativa <= mascara;
      comp_ativo    <= LW'(eff_len(int'(comprimento), W));
      modo_ativo    <= modo;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado <= IDLE;
    end else begin
      estado <= prox_estado;
    end
  end

  // Next state: loading a pattern aborts everything, start arms, a single-shot match parks in ACHADO.
  always_comb begin
    prox_estado = estado;
    if (setar_palavra) begin
      prox_estado = IDLE;
    end else if (start) begin
      prox_estado = BUSCA;
    end else if (achou && (modo_ativo == MODO_UNICO)) begin
      prox_estado = ACHADO;
    end
  end

  // Busy indication follows the searching state directly.
  always_comb begin
    ocupado = (estado == BUSCA);
  end

  // Match flag: pulses per match while searching, holds in ACHADO, cleared by setar/start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      encontrado <= 1'b0;
    end else if (limpar) begin
      encontrado <= 1'b0;
    end else if (estado == BUSCA) begin
      encontrado <= achou;
    end
  end

`ifdef SEQ_MATCH_COUNT_EN
  logic [CW-1:0] contador;

  // Saturating match counter; start leaves it alone so counts survive a re-arm.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      contador <= '0;
    end else if (setar_palavra) begin
      contador <= '0;
    end else if (achou && (contador != '1)) begin
      contador <= contador + CW'(1);
    end
  end

  assign contagem = contador;
`else
  assign contagem = '0;
`endif

endmodule

// File: tb/tb_detector_sequencia_param.sv
// Self-checking bench for detector_sequencia_param (W=8, CW=2).
// A table of per-cycle records drives the main scenarios; hand-written
// sequences cover reset defaults, setar/start collision with bit gaps and
// asynchronous reset in the middle of a search.
module tb_detector_sequencia_param;

  localparam int W  = 8;
  localparam int LW = $clog2(W + 1);
  localparam int CW = 2;
`ifdef SEQ_MATCH_COUNT_EN
  localparam bit COUNT_EN = 1'b1;
`else
  localparam bit COUNT_EN = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          setar_palavra;
  logic [W-1:0]  palavra;
  logic [W-1:0]  mascara;
  logic [LW-1:0] comprimento;
  logic          modo;
  logic          start;
  logic          bit_valid;
  logic          bit_in;
  logic          encontrado;
  logic          ocupado;
  logic [CW-1:0] contagem;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic          setar;
    logic          st;
    logic          vld;
    logic          b;
    logic [W-1:0]  pal;
    logic [W-1:0]  msk;
    logic [LW-1:0] comp;
    logic          md;
    logic          e_enc;
    logic          e_ocup;
    logic [CW-1:0] e_cnt;
  } vec_t;

  vec_t tbl[$];

  detector_sequencia_param #(
    .W  (W),
    .LW (LW),
    .CW (CW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .setar_palavra (setar_palavra),
    .palavra       (palavra),
    .mascara       (mascara),
    .comprimento   (comprimento),
    .modo          (modo),
    .start         (start),
    .bit_valid     (bit_valid),
    .bit_in        (bit_in),
    .encontrado    (encontrado),
    .ocupado       (ocupado),
    .contagem      (contagem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t cfgVec(input logic [W-1:0] p, input logic [W-1:0] m,
                                  input logic [LW-1:0] c, input logic md);
    vec_t v;
    v.setar = 1'b1; v.st = 1'b0; v.vld = 1'b1; v.b = 1'b1;
    v.pal = p; v.msk = m; v.comp = c; v.md = md;
    v.e_enc = 1'b0; v.e_ocup = 1'b0; v.e_cnt = '0;
    return v;
  endfunction

  // Config fields carry junk so that stray config changes outside setar would show up.
  function automatic vec_t bitVec(input logic st, input logic vld, input logic b,
                                  input logic e_enc, input logic e_ocup, input logic [CW-1:0] e_cnt);
    vec_t v;
    v.setar = 1'b0; v.st = st; v.vld = vld; v.b = b;
    v.pal = 8'h5A; v.msk = 8'hC3; v.comp = 4'd5; v.md = 1'b1;
    v.e_enc = e_enc; v.e_ocup = e_ocup; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    setar_palavra = v.setar;
    start         = v.st;
    bit_valid     = v.vld;
    bit_in        = v.b;
    palavra       = v.pal;
    mascara       = v.msk;
    comprimento   = v.comp;
    modo          = v.md;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic e_enc, input logic e_ocup,
                             input logic [CW-1:0] e_cnt);
    logic [CW-1:0] req_cnt;
    req_cnt = COUNT_EN ? e_cnt : '0;
    checks++;
    if (encontrado !== e_enc) begin
      errors++;
      $display("[TB] FAIL %s encontrado: got %b want %b", name, encontrado, e_enc);
    end
    checks++;
    if (ocupado !== e_ocup) begin
      errors++;
      $display("[TB] FAIL %s ocupado: got %b want %b", name, ocupado, e_ocup);
    end
    checks++;
    if (contagem !== req_cnt) begin
      errors++;
      $display("[TB] FAIL %s contagem: got %0d want %0d", name, contagem, req_cnt);
    end
  endtask

  initial begin
    vec_t v;

    // Table A: pattern 101, length 3, continuous mode, overlapping matches.
    tbl.push_back(cfgVec(8'h05, 8'hFF, 4'd3, 1'b1));
    tbl.push_back(bitVec(1, 0, 0, 0, 1, 0));
    tbl.push_back(bitVec(0, 1, 1, 0, 1, 0));
    tbl.push_back(bitVec(0, 1, 0, 0, 1, 0));
    tbl.push_back(bitVec(0, 1, 1, 1, 1, 1));
    tbl.push_back(bitVec(0, 1, 0, 0, 1, 1));
    tbl.push_back(bitVec(0, 1, 1, 1, 1, 2));
    tbl.push_back(bitVec(0, 0, 1, 0, 1, 2));
    tbl.push_back(bitVec(0, 1, 0, 0, 1, 2));
    // Table B: 8'hB4 full length, single-shot, sticky then re-armed.
    tbl.push_back(cfgVec(8'hB4, 8'hFF, 4'd8, 1'b0));
    tbl.push_back(bitVec(1, 0, 0, 0, 1, 0));
    tbl.push_back(bitVec(0, 1, 1, 0, 1, 0));
    tbl.push_back(bitVec(0, 1, 0, 0, 1, 0));
    tbl.push_back(bitVec(0, 1, 1, 0, 1, 0));
    tbl.push_back(bitVec(0, 1, 1, 0, 1, 0));
    tbl.push_back(bitVec(0, 1, 0, 0, 1, 0));
    tbl.push_back(bitVec(0, 1, 1, 0, 1, 0));
    tbl.push_back(bitVec(0, 1, 0, 0, 1, 0));
    tbl.push_back(bitVec(0, 1, 0, 1, 0, 1));
    tbl.push_back(bitVec(0, 1, 1, 1, 0, 1));
    tbl.push_back(bitVec(0, 1, 1, 1, 0, 1));
    tbl.push_back(bitVec(1, 1, 1, 0, 1, 1));
    tbl.push_back(bitVec(0, 0, 0, 0, 1, 1));
    // Table C: don't-care upper nibble; match then near miss with length 0 (= 8).
    tbl.push_back(cfgVec(8'hFF, 8'h0F, 4'd8, 1'b0));
    tbl.push_back(bitVec(1, 0, 0, 0, 1, 0));
    for (int i = 0; i < 7; i++) tbl.push_back(bitVec(0, 1, (i >= 4), 0, 1, 0));
    tbl.push_back(bitVec(0, 1, 1, 1, 0, 1));
    tbl.push_back(cfgVec(8'hFF, 8'h0F, 4'd0, 1'b0));
    tbl.push_back(bitVec(1, 0, 0, 0, 1, 0));
    for (int i = 0; i < 8; i++) tbl.push_back(bitVec(0, 1, (i >= 4 && i < 7), 0, 1, 0));
    // Table D: all-zero mask, length 2, continuous; counter saturates and survives start.
    tbl.push_back(cfgVec(8'h00, 8'h00, 4'd2, 1'b1));
    tbl.push_back(bitVec(1, 0, 0, 0, 1, 0));
    tbl.push_back(bitVec(0, 1, 1, 0, 1, 0));
    tbl.push_back(bitVec(0, 1, 0, 1, 1, 1));
    tbl.push_back(bitVec(0, 1, 1, 1, 1, 2));
    tbl.push_back(bitVec(0, 1, 1, 1, 1, 3));
    tbl.push_back(bitVec(0, 1, 0, 1, 1, 3));
    tbl.push_back(bitVec(0, 1, 1, 1, 1, 3));
    tbl.push_back(bitVec(1, 1, 1, 0, 1, 3));
    tbl.push_back(bitVec(0, 0, 0, 0, 1, 3));
    tbl.push_back(bitVec(0, 1, 0, 0, 1, 3));
    tbl.push_back(bitVec(0, 1, 0, 1, 1, 3));
    // Table E: length 9 clamps to 8; pattern 00000001.
    tbl.push_back(cfgVec(8'h01, 8'hFF, 4'd9, 1'b1));
    tbl.push_back(bitVec(1, 0, 0, 0, 1, 0));
    for (int i = 0; i < 7; i++) tbl.push_back(bitVec(0, 1, 0, 0, 1, 0));
    tbl.push_back(bitVec(0, 1, 1, 1, 1, 1));
    tbl.push_back(bitVec(0, 1, 0, 0, 1, 1));

    // Reset state.
    rst_n = 1'b0;
    v = bitVec(0, 0, 0, 0, 0, 0);
    applyStimulus(v);
    applyStimulus(v);
    checkOutput("reset", 1'b0, 1'b0, '0);
    rst_n = 1'b1;

    // Reset defaults: mask 0, length W, single-shot -> match on the 8th bit.
    applyStimulus(bitVec(1, 0, 0, 0, 0, 0));
    checkOutput("dflt_start", 1'b0, 1'b1, '0);
    for (int i = 0; i < 7; i++) applyStimulus(bitVec(0, 1, i[0], 0, 0, 0));
    checkOutput("dflt_bit7", 1'b0, 1'b1, '0);
    applyStimulus(bitVec(0, 1, 1, 0, 0, 0));
    checkOutput("dflt_bit8", 1'b1, 1'b0, 2'd1);

    // Table-driven scenarios.
    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i]);
      checkOutput($sformatf("vec%0d", i), tbl[i].e_enc, tbl[i].e_ocup, tbl[i].e_cnt);
    end

    // setar and start together: setar wins, block idles with new config.
    v = cfgVec(8'h05, 8'hFF, 4'd3, 1'b0);
    v.st = 1'b1;
    applyStimulus(v);
    checkOutput("setar_start", 1'b0, 1'b0, '0);
    // Start with a valid bit: that bit is dropped, then 0,1,0,1 with 3-cycle gaps.
    applyStimulus(bitVec(1, 1, 1, 0, 1, 0));
    checkOutput("gap_start", 1'b0, 1'b1, '0);
    applyStimulus(bitVec(0, 1, 0, 0, 0, 0));
    checkOutput("gap_b1", 1'b0, 1'b1, '0);
    for (int i = 0; i < 3; i++) applyStimulus(bitVec(0, 0, 1, 0, 0, 0));
    checkOutput("gap_idle1", 1'b0, 1'b1, '0);
    applyStimulus(bitVec(0, 1, 1, 0, 0, 0));
    checkOutput("gap_b2", 1'b0, 1'b1, '0);
    for (int i = 0; i < 3; i++) applyStimulus(bitVec(0, 0, 0, 0, 0, 0));
    applyStimulus(bitVec(0, 1, 0, 0, 0, 0));
    checkOutput("gap_b3", 1'b0, 1'b1, '0);
    for (int i = 0; i < 3; i++) applyStimulus(bitVec(0, 0, 1, 0, 0, 0));
    applyStimulus(bitVec(0, 1, 1, 0, 0, 0));
    checkOutput("gap_match", 1'b1, 1'b0, 2'd1);
    applyStimulus(bitVec(0, 1, 0, 0, 0, 0));
    checkOutput("gap_sticky", 1'b1, 1'b0, 2'd1);

    // Asynchronous reset in the middle of a search with fill = 5.
    applyStimulus(cfgVec(8'h00, 8'h00, 4'd5, 1'b1));
    applyStimulus(bitVec(1, 0, 0, 0, 0, 0));
    for (int i = 0; i < 4; i++) applyStimulus(bitVec(0, 1, 1, 0, 0, 0));
    checkOutput("pre_rst_bit4", 1'b0, 1'b1, '0);
    applyStimulus(bitVec(0, 1, 0, 0, 0, 0));
    checkOutput("pre_rst_bit5", 1'b1, 1'b1, 2'd1);
    #2 rst_n = 1'b0;
    #1 checkOutput("async_rst", 1'b0, 1'b0, '0);
    #2 rst_n = 1'b1;
    applyStimulus(bitVec(0, 1, 1, 0, 0, 0));
    checkOutput("post_rst_idle", 1'b0, 1'b0, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
